// File: rtl/axis_tlp_pkt_fifo.sv
// axis_tlp_pkt_fifo: AXI4-Stream packet FIFO with store-and-forward, tuser discard and oversize drop
module axis_tlp_pkt_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int ADDR_WIDTH = 9,
  parameter bit STORE_FWD = 1'b1,
  parameter bit DROP_OVERSIZE = 1'b1
) (
  input  logic                  user_clk,
  input  logic                  user_reset,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic                  s_axis_tlast,
  input  logic                  s_axis_tuser,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic [ADDR_WIDTH:0]   pkt_count,
  output logic [15:0]           drop_count,
  output logic                  drop_pulse
);
  localparam int EW = DATA_WIDTH + KEEP_WIDTH + 1;
  localparam logic [ADDR_WIDTH:0] ONE = (ADDR_WIDTH + 1)'(1);
  localparam logic [ADDR_WIDTH:0] DEPTH = ONE << ADDR_WIDTH;
  typedef enum logic [1:0] {IDLE, PKT, DROP} state_t;
  state_t state;
  logic [EW-1:0] mem [2**ADDR_WIDTH];
  logic [EW-1:0] rd_q;
  logic [ADDR_WIDTH:0] rd_ptr, wr_ptr, wr_cur, wr_nxt;
  logic rd_v, full, fill, acc, wr_en, push_last, pop_last, drop, out_ld, ren;
  assign wr_nxt = wr_cur + ONE;
  assign full = (wr_cur - rd_ptr) == DEPTH;
  // a non-last beat that takes the final slot means the packet cannot fit; drop it without ever stalling
  assign fill = (wr_nxt - rd_ptr) == DEPTH;
  assign s_axis_tready = !user_reset && (state == DROP || !full);
  assign acc = s_axis_tvalid && s_axis_tready;
  assign wr_en = acc && state != DROP;
  assign drop = acc && s_axis_tlast && (state == DROP || (STORE_FWD && s_axis_tuser));
  assign push_last = wr_en && s_axis_tlast && !(STORE_FWD && s_axis_tuser);
  assign pop_last = m_axis_tvalid && m_axis_tready && m_axis_tlast;
  assign out_ld = rd_v && (!m_axis_tvalid || m_axis_tready);
  assign ren = rd_ptr != wr_ptr && (!rd_v || out_ld);
  // write FSM: speculative/committed pointers, rewind on discard or oversize, drop accounting
  always_ff @(posedge user_clk) begin
    if (user_reset) begin
      state <= IDLE;
      wr_cur <= '0;
      wr_ptr <= '0;
      drop_count <= '0;
      drop_pulse <= 1'b0;
    end else begin
      drop_pulse <= drop;
      if (drop && !(&drop_count)) drop_count <= drop_count + 16'd1;
      if (state == DROP) begin
        if (acc && s_axis_tlast) begin
          wr_cur <= wr_ptr;
          state <= IDLE;
        end
      end else if (acc) begin
        if (!STORE_FWD) begin
          wr_cur <= wr_nxt;
          wr_ptr <= wr_nxt;
          state <= s_axis_tlast ? IDLE : PKT;
        end else if (s_axis_tlast) begin
          state <= IDLE;
          wr_cur <= s_axis_tuser ? wr_ptr : wr_nxt;
          wr_ptr <= s_axis_tuser ? wr_ptr : wr_nxt;
        end else begin
          wr_cur <= wr_nxt;
          state <= (DROP_OVERSIZE && fill) ? DROP : PKT;
        end
      end
    end
  end
  // beat storage with a registered read port
  always_ff @(posedge user_clk) begin
    if (wr_en) mem[wr_cur[ADDR_WIDTH-1:0]] <= {s_axis_tlast, s_axis_tkeep, s_axis_tdata};
    if (ren) rd_q <= mem[rd_ptr[ADDR_WIDTH-1:0]];
  end
  // read pipeline: RAM read stage feeding the output register, which holds until handshake
  always_ff @(posedge user_clk) begin
    if (user_reset) begin
      rd_ptr <= '0;
      rd_v <= 1'b0;
      m_axis_tvalid <= 1'b0;
      {m_axis_tlast, m_axis_tkeep, m_axis_tdata} <= '0;
    end else begin
      if (ren) rd_ptr <= rd_ptr + ONE;
      rd_v <= ren || (rd_v && !out_ld);
      if (out_ld) {m_axis_tlast, m_axis_tkeep, m_axis_tdata} <= rd_q;
      m_axis_tvalid <= out_ld || (m_axis_tvalid && !m_axis_tready);
    end
  end
  // committed-packet occupancy
  always_ff @(posedge user_clk) begin
    if (user_reset) pkt_count <= '0;
    else if (push_last != pop_last) pkt_count <= push_last ? pkt_count + ONE : pkt_count - ONE;
  end
endmodule

// File: tb/tb_axis_tlp_pkt_fifo.sv
// tb_axis_tlp_pkt_fifo: self-checking bench for axis_tlp_pkt_fifo over three parameter sets
module tb_axis_tlp_pkt_fifo;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  int n_chk = 0;
  int n_fail = 0;
  logic [31:0] a_sd, a_md, b_sd, b_md;
  logic [3:0] a_sk, a_mk, b_sk, b_mk;
  logic a_sl, a_su, a_sv, a_sr, a_ml, a_mv, a_mr, a_dp;
  logic b_sl, b_su, b_sv, b_sr, b_ml, b_mv, b_mr, b_dp;
  logic [4:0] a_pc, b_pc;
  logic [15:0] a_dc, b_dc;
  logic [63:0] c_sd, c_md;
  logic [7:0] c_sk, c_mk;
  logic c_sl, c_su, c_sv, c_sr, c_ml, c_mv, c_mr, c_dp;
  logic [9:0] c_pc;
  logic [15:0] c_dc;
  axis_tlp_pkt_fifo #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .STORE_FWD(1'b1), .DROP_OVERSIZE(1'b1)) dut_a (
    .user_clk(clk), .user_reset(rst),
    .s_axis_tdata(a_sd), .s_axis_tkeep(a_sk), .s_axis_tlast(a_sl), .s_axis_tuser(a_su),
    .s_axis_tvalid(a_sv), .s_axis_tready(a_sr),
    .m_axis_tdata(a_md), .m_axis_tkeep(a_mk), .m_axis_tlast(a_ml), .m_axis_tvalid(a_mv),
    .m_axis_tready(a_mr), .pkt_count(a_pc), .drop_count(a_dc), .drop_pulse(a_dp));
  axis_tlp_pkt_fifo #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .STORE_FWD(1'b0), .DROP_OVERSIZE(1'b1)) dut_b (
    .user_clk(clk), .user_reset(rst),
    .s_axis_tdata(b_sd), .s_axis_tkeep(b_sk), .s_axis_tlast(b_sl), .s_axis_tuser(b_su),
    .s_axis_tvalid(b_sv), .s_axis_tready(b_sr),
    .m_axis_tdata(b_md), .m_axis_tkeep(b_mk), .m_axis_tlast(b_ml), .m_axis_tvalid(b_mv),
    .m_axis_tready(b_mr), .pkt_count(b_pc), .drop_count(b_dc), .drop_pulse(b_dp));
  axis_tlp_pkt_fifo #(.DATA_WIDTH(64), .ADDR_WIDTH(9), .STORE_FWD(1'b1), .DROP_OVERSIZE(1'b0)) dut_c (
    .user_clk(clk), .user_reset(rst),
    .s_axis_tdata(c_sd), .s_axis_tkeep(c_sk), .s_axis_tlast(c_sl), .s_axis_tuser(c_su),
    .s_axis_tvalid(c_sv), .s_axis_tready(c_sr),
    .m_axis_tdata(c_md), .m_axis_tkeep(c_mk), .m_axis_tlast(c_ml), .m_axis_tvalid(c_mv),
    .m_axis_tready(c_mr), .pkt_count(c_pc), .drop_count(c_dc), .drop_pulse(c_dp));
  typedef struct {
    logic sv;
    logic [31:0] sd;
    logic sl;
    logic ev;
    logic [31:0] ed;
    logic el;
    logic er;
    logic [4:0] ep;
  } vec_t;
  vec_t tv[10];
  logic [36:0] qa[$];
  logic [36:0] qb[$];
  logic [72:0] qc[$];
  logic [72:0] c_exp;
  int a_drops = 0;
  int c_committed = 0;
  int c_delivered = 0;
  bit c_on = 1'b0;
  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic send_a(input logic [31:0] d, input logic l, input logic u, output bit stalled);
    logic acc;
    acc = 1'b0;
    stalled = 1'b0;
    a_sv = 1'b1; a_sd = d; a_sl = l; a_su = u; a_sk = 4'hF;
    for (int k = 0; k < 200 && !acc; k++) begin
      @(negedge clk);
      acc = a_sr;
      if (!acc) stalled = 1'b1;
      @(posedge clk);
      #1;
    end
    a_sv = 1'b0; a_sl = 1'b0; a_su = 1'b0;
    if (!acc) begin
      n_chk++;
      n_fail++;
      $display("FAIL send_a_timeout: beat %0h not accepted within 200 cycles", d);
    end
  endtask
  task automatic send_pkt_a(input logic [31:0] base, input int len, input bit user, output bit stalled);
    bit st;
    stalled = 1'b0;
    for (int b = 0; b < len; b++) begin
      send_a(base + 32'(b), b == len - 1, user && b == len - 1, st);
      stalled = stalled | st;
    end
  endtask
  // output monitors: capture handshaken beats away from the active edge
  always @(negedge clk) begin
    if (!rst) begin
      if (a_mv && a_mr) qa.push_back({a_ml, a_mk, a_md});
      if (a_dp) a_drops++;
    end
  end
  always @(negedge clk) begin
    if (!rst && b_mv && b_mr) qb.push_back({b_ml, b_mk, b_md});
  end
  always @(negedge clk) begin
    if (c_on && !rst) begin
      chk("c_pkt_count", 96'(c_pc), 96'(10'(c_committed - c_delivered)));
      if (c_mv && c_mr) begin
        if (qc.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL c_unexpected_beat: got %0h with empty scoreboard", {c_ml, c_mk, c_md});
        end else begin
          c_exp = qc.pop_front();
          chk("c_beat", 96'({c_ml, c_mk, c_md}), 96'(c_exp));
        end
        if (c_ml) c_delivered++;
      end
    end
  end
  initial begin
    forever begin
      @(posedge clk);
      #1;
      c_mr = $urandom_range(0, 99) < 75;
    end
  end
  initial begin
    #1500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end
  initial begin
    bit st;
    logic a;
    int i, guard, d0, disc_n, len;
    bit disc, acc, seen;
    logic [72:0] pk[$];
    tv[0] = '{1'b1, 32'hA0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 5'd0};
    tv[1] = '{1'b1, 32'hA1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 5'd0};
    tv[2] = '{1'b1, 32'hA2, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 5'd0};
    tv[3] = '{1'b1, 32'hA3, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 5'd1};
    tv[4] = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 5'd1};
    tv[5] = '{1'b0, 32'h0, 1'b0, 1'b1, 32'hA0, 1'b0, 1'b1, 5'd1};
    tv[6] = '{1'b0, 32'h0, 1'b0, 1'b1, 32'hA1, 1'b0, 1'b1, 5'd1};
    tv[7] = '{1'b0, 32'h0, 1'b0, 1'b1, 32'hA2, 1'b0, 1'b1, 5'd1};
    tv[8] = '{1'b0, 32'h0, 1'b0, 1'b1, 32'hA3, 1'b1, 1'b1, 5'd1};
    tv[9] = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 5'd0};
    {a_sd, a_sk, a_sl, a_su, a_sv, a_mr} = '0;
    {b_sd, b_sk, b_sl, b_su, b_sv, b_mr} = '0;
    {c_sd, c_sk, c_sl, c_su, c_sv} = '0;
    a_mr = 1'b1;
    rst = 1'b1;
    tick(3);
    chk("rst_s_tready", 96'(a_sr), 96'(0));
    chk("rst_m_tvalid", 96'(a_mv), 96'(0));
    chk("rst_pkt_count", 96'(a_pc), 96'(0));
    chk("rst_drop_count", 96'(a_dc), 96'(0));
    chk("rst_drop_pulse", 96'(a_dp), 96'(0));
    chk("rst_m_out", 96'({a_ml, a_mk, a_md}), 96'(0));
    chk("rst_b_m_tvalid", 96'(b_mv), 96'(0));
    chk("rst_c_m_tvalid", 96'(c_mv), 96'(0));
    rst = 1'b0;
    #1;
    chk("s_tready_after_rst", 96'(a_sr), 96'(1));
    // single 4-beat packet: store-and-forward latency and in-order drain
    for (int r = 0; r < 10; r++) begin
      a_sv = tv[r].sv; a_sd = tv[r].sd; a_sl = tv[r].sl; a_sk = 4'hF; a_su = 1'b0;
      tick(1);
      chk($sformatf("vec%0d_m_tvalid", r), 96'(a_mv), 96'(tv[r].ev));
      chk($sformatf("vec%0d_pkt_count", r), 96'(a_pc), 96'(tv[r].ep));
      chk($sformatf("vec%0d_s_tready", r), 96'(a_sr), 96'(tv[r].er));
      if (tv[r].ev) chk($sformatf("vec%0d_m_out", r), 96'({a_ml, a_mk, a_md}), 96'({tv[r].el, 4'hF, tv[r].ed}));
    end
    a_sv = 1'b0; a_sl = 1'b0;
    tick(3);
    qa.delete();
    // discarded packet followed by a good one
    d0 = a_drops;
    send_pkt_a(32'hD0, 3, 1'b1, st);
    send_pkt_a(32'hB0, 2, 1'b0, st);
    tick(8);
    chk("disc_out_count", 96'(qa.size()), 96'(2));
    if (qa.size() == 2) begin
      chk("disc_beat0", 96'(qa[0]), 96'({1'b0, 4'hF, 32'hB0}));
      chk("disc_beat1", 96'(qa[1]), 96'({1'b1, 4'hF, 32'hB1}));
    end
    chk("disc_drop_count", 96'(a_dc), 96'(1));
    chk("disc_drop_pulses", 96'(a_drops - d0), 96'(1));
    // oversize: 20 beats into a 16-entry RAM with the output blocked
    a_mr = 1'b0;
    qa.delete();
    d0 = a_drops;
    send_pkt_a(32'h300, 20, 1'b0, st);
    chk("ovs_never_stalled", 96'(st), 96'(0));
    tick(5);
    chk("ovs_m_tvalid", 96'(a_mv), 96'(0));
    chk("ovs_out_count", 96'(qa.size()), 96'(0));
    chk("ovs_drop_count", 96'(a_dc), 96'(2));
    chk("ovs_drop_pulses", 96'(a_drops - d0), 96'(1));
    chk("ovs_pkt_count", 96'(a_pc), 96'(0));
    a_mr = 1'b1;
    send_pkt_a(32'hF0, 2, 1'b0, st);
    tick(8);
    chk("ovs_next_count", 96'(qa.size()), 96'(2));
    if (qa.size() == 2) begin
      chk("ovs_next_beat0", 96'(qa[0]), 96'({1'b0, 4'hF, 32'hF0}));
      chk("ovs_next_beat1", 96'(qa[1]), 96'({1'b1, 4'hF, 32'hF1}));
    end
    // cut-through back-pressure: RAM holds 16 beats and two more sit in the read pipeline
    b_mr = 1'b0;
    qb.delete();
    i = 0; guard = 0; seen = 1'b0;
    while (i < 20 && guard < 400) begin
      b_sv = 1'b1; b_sd = 32'h100 + i; b_sk = 4'(i); b_sl = i == 19;
      @(negedge clk);
      a = b_sr;
      tick(1);
      if (a) i++;
      else if (!seen) begin
        seen = 1'b1;
        chk("bp_accepted_at_full", 96'(i), 96'(18));
        for (int k = 0; k < 5; k++) begin
          chk("bp_hold_valid", 96'(b_mv), 96'(1));
          chk("bp_hold_data", 96'({b_ml, b_mk, b_md}), 96'({1'b0, 4'h0, 32'h100}));
          tick(1);
        end
        b_mr = 1'b1;
      end
      guard++;
    end
    b_sv = 1'b0; b_sl = 1'b0;
    chk("bp_full_seen", 96'(seen), 96'(1));
    chk("bp_all_accepted", 96'(i), 96'(20));
    tick(30);
    chk("bp_out_count", 96'(qb.size()), 96'(20));
    for (int k = 0; k < qb.size(); k++)
      chk($sformatf("bp_beat%0d", k), 96'(qb[k]), 96'({k == 19, 4'(k), 32'(32'h100 + k)}));
    chk("bp_pkt_count", 96'(b_pc), 96'(0));
    // reset in the middle of a packet while a committed packet waits at the output
    a_mr = 1'b0;
    send_pkt_a(32'hC0, 2, 1'b0, st);
    tick(4);
    chk("prerst_m_tvalid", 96'(a_mv), 96'(1));
    chk("prerst_pkt_count", 96'(a_pc), 96'(1));
    send_a(32'hE8, 1'b0, 1'b0, st);
    a_sv = 1'b1; a_sd = 32'hE9; a_sl = 1'b0; a_su = 1'b0;
    rst = 1'b1;
    tick(1);
    chk("midrst_m_tvalid", 96'(a_mv), 96'(0));
    chk("midrst_pkt_count", 96'(a_pc), 96'(0));
    chk("midrst_drop_count", 96'(a_dc), 96'(0));
    rst = 1'b0;
    a_sv = 1'b0;
    a_mr = 1'b1;
    qa.delete();
    send_pkt_a(32'hE0, 4, 1'b0, st);
    tick(10);
    chk("postrst_out_count", 96'(qa.size()), 96'(4));
    for (int k = 0; k < qa.size(); k++)
      chk($sformatf("postrst_beat%0d", k), 96'(qa[k]), 96'({k == 3, 4'hF, 32'(32'hE0 + k)}));
    chk("postrst_drop_count", 96'(a_dc), 96'(0));
    chk("postrst_pkt_count", 96'(a_pc), 96'(0));
    // random throttled traffic against a packet-level scoreboard
    c_on = 1'b1;
    disc_n = 0;
    for (int p = 0; p < 1000; p++) begin
      len = $urandom_range(1, 32);
      disc = $urandom_range(0, 99) < 5;
      pk.delete();
      for (int b = 0; b < len; b++) begin
        while ($urandom_range(0, 99) < 30) begin
          c_sv = 1'b0;
          tick(1);
        end
        c_sv = 1'b1;
        c_sd = {$urandom, $urandom};
        c_sk = 8'($urandom);
        c_sl = b == len - 1;
        c_su = c_sl ? disc : 1'($urandom);
        acc = 1'b0;
        for (int k = 0; k < 1000 && !acc; k++) begin
          @(negedge clk);
          acc = c_sr;
          tick(1);
        end
        if (!acc) begin
          n_chk++;
          n_fail++;
          $display("FAIL c_send_timeout: packet %0d beat %0d not accepted", p, b);
        end
        pk.push_back({c_sl, c_sk, c_sd});
      end
      c_sv = 1'b0; c_sl = 1'b0; c_su = 1'b0;
      if (disc) disc_n++;
      else begin
        foreach (pk[k]) qc.push_back(pk[k]);
        c_committed++;
      end
    end
    for (int k = 0; k < 5000 && qc.size() != 0; k++) tick(1);
    tick(3);
    c_on = 1'b0;
    chk("c_drained", 96'(qc.size()), 96'(0));
    chk("c_final_pkt_count", 96'(c_pc), 96'(0));
    chk("c_drop_count", 96'(c_dc), 96'(disc_n));
    chk("c_packets_delivered", 96'(c_delivered), 96'(1000 - disc_n));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
